// File: rtl/disp_pkg.sv
// Shared types and helpers for the barrido_digitos multiplexed display scanner.
// Holds the scan state encoding, counter-width helper and anode polarity encoder.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } disp_state_e;

  // Widest display the anode encoder supports; callers size-cast the result down.
  localparam int MAX_DIGITS = 32;
  localparam int IDX_W      = 5;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One-hot anode pattern for digit idx; with valid=0 every anode is inactive.
  function automatic logic [MAX_DIGITS-1:0] anode_drive(
    input logic [IDX_W-1:0] idx,
    input logic             valid,
    input logic             active_low
  );
    logic [MAX_DIGITS-1:0] one_hot;
    one_hot = '0;
    if (valid) one_hot[idx] = 1'b1;
    return active_low ? ~one_hot : one_hot;
  endfunction

endpackage

// File: rtl/rr_next_digit.sv
// Combinational round-robin search over the digit enable mask: lowest enabled
// digit above the current one (wrapping), the lowest enabled digit, and any-valid.
module rr_next_digit
  import disp_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SEL_W    = $clog2(N_DIGITS)
) (
  input  logic [N_DIGITS-1:0] i_Mask,
  input  logic [SEL_W-1:0]    i_Cur,
  output logic [SEL_W-1:0]    o_Next,
  output logic [SEL_W-1:0]    o_First,
  output logic                o_Any
);

  logic [SEL_W-1:0] above_idx;
  logic             above_found;

  // NOTE: every variable written here gets a default first, otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    o_First     = '0;
    above_idx   = '0;
    above_found = 1'b0;
    // Scanning downwards leaves the lowest qualifying index as the last write.
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (i_Mask[i]) begin
        o_First = SEL_W'(i);
        if (32'(i) > 32'(i_Cur)) begin
          above_idx   = SEL_W'(i);
          above_found = 1'b1;
        end
      end
    end
    o_Next = above_found ? above_idx : o_First;
    o_Any  = |i_Mask;
  end

endmodule

// File: rtl/barrido_digitos.sv
// Multiplexed 7-segment digit scanner: slot prescaler, masked round-robin digit
// select, inter-digit blanking and idle mode. Define DISP_SCAN_DIM_EN for i_Bright dimming.
module barrido_digitos
  import disp_pkg::*;
#(
  parameter  int N_DIGITS         = 4,
  parameter  int PRESCALE         = 50000,
  parameter  int BLANK_CYC        = 16,
  parameter  int ANODE_ACTIVE_LOW = 1,
  localparam int SEL_W            = $clog2(N_DIGITS)
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_En,
  input  logic [N_DIGITS-1:0] i_Dig_Mask,
`ifdef DISP_SCAN_DIM_EN
  input  logic [3:0]          i_Bright,
`endif
  output logic [N_DIGITS-1:0] o_Anodo,
  output logic [SEL_W-1:0]    o_Sel,
  output logic                o_Slot_Start,
  output logic                o_Blank
);

  localparam int                  PC_W      = cnt_width(PRESCALE);
  localparam logic [PC_W-1:0]     PC_LAST   = PC_W'(PRESCALE - 1);
  localparam logic [31:0]         BLANK_U   = 32'(BLANK_CYC);
  localparam logic [31:0]         FULL_END  = 32'(PRESCALE);
  localparam logic                POL_LOW   = (ANODE_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] ANODE_OFF = POL_LOW ? '1 : '0;

  logic [PC_W-1:0]     pc_q, pc_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  disp_state_e         state_q, state_d;
  logic [N_DIGITS-1:0] anodo_q, anodo_d;
  logic                blank_q, blank_d;
  logic                slot_start_q, slot_start_d;
`ifdef DISP_SCAN_DIM_EN
  logic [3:0]          bright_q, bright_d;
`endif

  logic [SEL_W-1:0]    rr_next;
  logic [SEL_W-1:0]    rr_first;
  logic                any_valid;
  logic [31:0]         drive_end;
  logic                in_window;
  logic                lit;

  rr_next_digit #(
    .N_DIGITS (N_DIGITS),
    .SEL_W    (SEL_W)
  ) u_rr (
    .i_Mask  (i_Dig_Mask),
    .i_Cur   (sel_q),
    .o_Next  (rr_next),
    .o_First (rr_first),
    .o_Any   (any_valid)
  );

  always_comb begin
    pc_d         = pc_q;
    sel_d        = sel_q;
    state_d      = state_q;
    slot_start_d = 1'b0;
    drive_end    = FULL_END;
    in_window    = 1'b0;
    lit          = 1'b0;
`ifdef DISP_SCAN_DIM_EN
    bright_d     = bright_q;
`endif

    if (!i_En || !any_valid) begin
      pc_d    = '0;
      sel_d   = '0;
      state_d = IDLE;
    end else begin
      if (state_q == IDLE || pc_q == PC_LAST) begin
        pc_d         = '0;
        sel_d        = (state_q == IDLE) ? rr_first : rr_next;
        slot_start_d = 1'b1;
`ifdef DISP_SCAN_DIM_EN
        bright_d     = i_Bright;
`endif
      end else begin
        pc_d = pc_q + PC_W'(1);
      end

`ifdef DISP_SCAN_DIM_EN
      // Drive window scales in sixteenths of the non-blanked part of the slot.
      drive_end = BLANK_U + (32'(PRESCALE - BLANK_CYC) * (32'(bright_d) + 32'd1)) / 32'd16;
`endif
      in_window = (32'(pc_d) >= BLANK_U) && (32'(pc_d) < drive_end);
      state_d   = in_window ? DRIVE : BLANK;
      // A digit whose mask bit drops mid-slot goes dark but keeps its slot.
      lit       = in_window && i_Dig_Mask[sel_d];
    end

    anodo_d = N_DIGITS'(anode_drive(IDX_W'(sel_d), lit, POL_LOW));
    blank_d = !lit;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      pc_q         <= '0;
      sel_q        <= '0;
      state_q      <= IDLE;
      anodo_q      <= ANODE_OFF;
      blank_q      <= 1'b1;
      slot_start_q <= 1'b0;
`ifdef DISP_SCAN_DIM_EN
      bright_q     <= 4'hF;
`endif
    end else begin
      pc_q         <= pc_d;
      sel_q        <= sel_d;
      state_q      <= state_d;
      anodo_q      <= anodo_d;
      blank_q      <= blank_d;
      slot_start_q <= slot_start_d;
`ifdef DISP_SCAN_DIM_EN
      bright_q     <= bright_d;
`endif
    end
  end

  assign o_Anodo      = anodo_q;
  assign o_Sel        = sel_q;
  assign o_Slot_Start = slot_start_q;
  assign o_Blank      = blank_q;

endmodule

// File: tb/tb_barrido_digitos.sv
// Self-checking bench for barrido_digitos: cycle model feeds a scoreboard queue,
// plus directed sequence, masking, idle, reset and (with DISP_SCAN_DIM_EN) dimming checks.
module tb_barrido_digitos;

  localparam int N_DIGITS  = 4;
`ifdef DISP_SCAN_DIM_EN
  localparam int PRESCALE  = 34;
`else
  localparam int PRESCALE  = 8;
`endif
  localparam int BLANK_CYC = 2;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef struct packed {
    logic [3:0] anodo;
    logic [1:0] sel;
    logic       start;
    logic       blank;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] mask;
  logic [3:0] anodo;
  logic [1:0] sel;
  logic       slot_start;
  logic       blank;
`ifdef DISP_SCAN_DIM_EN
  logic [3:0] bright;
  int         m_bright;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  int   seq_q[$];
  int   exp_q[$];
  int   active_cnt;
  bit   m_idle = 1'b1;
  int   m_pc   = 0;
  int   m_sel  = 0;

  always #5 clk = ~clk;

  barrido_digitos #(
    .N_DIGITS         (N_DIGITS),
    .PRESCALE         (PRESCALE),
    .BLANK_CYC        (BLANK_CYC),
    .ANODE_ACTIVE_LOW (1)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_En         (en),
    .i_Dig_Mask   (mask),
`ifdef DISP_SCAN_DIM_EN
    .i_Bright     (bright),
`endif
    .o_Anodo      (anodo),
    .o_Sel        (sel),
    .o_Slot_Start (slot_start),
    .o_Blank      (blank)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [3:0] m);
    for (int i = 0; i < N_DIGITS; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_after(input logic [3:0] m, input int cur);
    for (int k = 1; k <= N_DIGITS; k++) begin
      if (m[(cur + k) % N_DIGITS]) return (cur + k) % N_DIGITS;
    end
    return 0;
  endfunction

  // Predicts the outputs registered at the coming edge from the current inputs.
  task automatic model_step();
    exp_t e;
    int   on_cnt;
    bit   lit;
    e = '{anodo: ANODE_OFF, sel: 2'd0, start: 1'b0, blank: 1'b1};
    if (!rst_n || !en || mask == 4'd0) begin
      m_idle = 1'b1;
      m_pc   = 0;
      m_sel  = 0;
    end else begin
      if (m_idle || m_pc == PRESCALE - 1) begin
        m_sel   = m_idle ? first_set(mask) : next_after(mask, m_sel);
        m_pc    = 0;
        m_idle  = 1'b0;
        e.start = 1'b1;
`ifdef DISP_SCAN_DIM_EN
        m_bright = int'(bright);
`endif
      end else begin
        m_pc++;
      end
      on_cnt = PRESCALE - BLANK_CYC;
`ifdef DISP_SCAN_DIM_EN
      on_cnt = on_cnt * (m_bright + 1) / 16;
`endif
      lit   = (m_pc >= BLANK_CYC) && (m_pc < BLANK_CYC + on_cnt) && mask[m_sel];
      e.sel = 2'(m_sel);
      if (lit) begin
        e.anodo = ~(4'b0001 << m_sel);
        e.blank = 1'b0;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("anodo", 32'(anodo), 32'(e.anodo));
      check("sel", 32'(sel), 32'(e.sel));
      check("slot_start", 32'(slot_start), 32'(e.start));
      check("blank", 32'(blank), 32'(e.blank));
    end
    check("onehot", ($countones(~anodo) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run_slots(input int n);
    seq_q.delete();
    active_cnt = 0;
    repeat (n * PRESCALE) begin
      tick();
      if (slot_start) seq_q.push_back(int'(sel));
      if (anodo != ANODE_OFF) active_cnt++;
    end
  endtask

  task automatic compare_seq(input string tag);
    check({tag, "_len"}, 32'(seq_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seq_q.size(); i++)
      check($sformatf("%s_sel%0d", tag, i), 32'(seq_q[i]), 32'(exp_q[i]));
  endtask

  task automatic align();
    int guard = 0;
    while (m_pc != PRESCALE - 1 && guard < 2 * PRESCALE) begin
      tick();
      guard++;
    end
    check("align", 32'(m_pc), 32'(PRESCALE - 1));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_anodo"}, 32'(anodo), 32'(ANODE_OFF));
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_blank"}, 32'(blank), 32'd1);
    check({tag, "_start"}, 32'(slot_start), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mask  = 4'b0000;
`ifdef DISP_SCAN_DIM_EN
    bright   = 4'hF;
    m_bright = 15;
`endif
    @(negedge clk);
    tick();
    tick();
    check_reset_outs("reset");

    // Full mask from idle: 0,1,2,3,0 with 2 blank + 6 drive cycles each.
    rst_n = 1'b1;
    en    = 1'b1;
    mask  = 4'b1111;
    run_slots(5);
    exp_q = {0, 1, 2, 3, 0};
    compare_seq("full");
    check("full_active", 32'(active_cnt), 32'(5 * (PRESCALE - BLANK_CYC)));

    mask = 4'b1010;
    run_slots(3);
    exp_q = {1, 3, 1};
    compare_seq("alt");
    check("alt_active", 32'(active_cnt), 32'(3 * (PRESCALE - BLANK_CYC)));

    mask = 4'b0100;
    run_slots(3);
    exp_q = {2, 2, 2};
    compare_seq("single");

    // Clear the current digit's mask bit mid-drive.
    mask = 4'b1111;
    run_slots(1);
    exp_q = {3};
    compare_seq("wrap");
    repeat (5) tick();
    check("pc4_sel", 32'(sel), 32'd0);
    check("pc4_anodo", 32'(anodo), 32'(4'b1110));
    mask = 4'b1110;
    tick();
    check("clr_anodo", 32'(anodo), 32'(ANODE_OFF));
    check("clr_blank", 32'(blank), 32'd1);
    align();
    tick();
    check("clr_next_start", 32'(slot_start), 32'd1);
    check("clr_next_sel", 32'(sel), 32'd1);

    // Enable dropped mid-drive, then re-enabled with a new mask.
    repeat (3) tick();
    check("drv1_anodo", 32'(anodo), 32'(4'b1101));
    en = 1'b0;
    tick();
    check_reset_outs("en_off");
    en   = 1'b1;
    mask = 4'b1100;
    tick();
    check("reen_start", 32'(slot_start), 32'd1);
    check("reen_sel", 32'(sel), 32'd2);

    // Reset asserted for one edge during digit 3 drive.
    align();
    tick();
    check("d3_sel", 32'(sel), 32'd3);
    repeat (3) tick();
    check("d3_anodo", 32'(anodo), 32'(4'b0111));
    rst_n = 1'b0;
    tick();
    check_reset_outs("mid_rst");
    rst_n = 1'b1;
    tick();
    check("post_rst_sel", 32'(sel), 32'd2);

`ifdef DISP_SCAN_DIM_EN
    mask = 4'b0001;
    align();
    bright = 4'd7;
    run_slots(2);
    check("dim7_active", 32'(active_cnt), 32'(2 * 16));
    bright = 4'd15;
    run_slots(2);
    check("dim15_active", 32'(active_cnt), 32'(2 * 32));
`else
    mask = 4'b0001;
    align();
    run_slots(2);
    exp_q = {0, 0};
    compare_seq("only0");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
